// File: rtl/issue_scheduler.sv
// -----------------------------------------------------------------------------
// issue_scheduler
//   In-order issue queue with per-unit credit scheduling, sitting between decode
//   and the ISSUE_UNIT. Decoded {unit_sel, uop} pairs are buffered in a small
//   circular queue. The head entry is released only when its target unit
//   (INT/VEC/LSU) has a free credit. A blocked head blocks everything behind it.
//
// Ports
//   clock_in           : clock, all state updates on the rising edge
//   reset_in           : asynchronous active-low reset
//   flush_in           : synchronous flush of queued, not-yet-issued entries
//   dec_valid_in       : decode offers an entry
//   dec_unit_sel_in    : one-hot target unit (001 INT, 010 VEC, 100 LSU)
//   dec_uop_in         : micro-op
//   dec_ready_out      : queue can accept this cycle
//   int_done_in        : INT retires one op (returns one credit)
//   vec_done_in        : VEC retires one op
//   lsu_done_in        : LSU retires one op
//   exec_unit_sel_out  : issued unit select, 000 when nothing issues
//   exec_uop_out       : issued micro-op, 0000 when nothing issues
//   issue_valid_out    : head entry issues this cycle
//   illegal_sel_out    : one-cycle pulse after a non-one-hot select was accepted
//   stall_count_out    : saturating count of cycles the head was blocked
// -----------------------------------------------------------------------------
module issue_scheduler #(
  parameter int QUEUE_DEPTH = 4,
  parameter int INT_CREDITS = 1,
  parameter int VEC_CREDITS = 2,
  parameter int LSU_CREDITS = 2
) (
  input  logic        clock_in,
  input  logic        reset_in,
  input  logic        flush_in,
  input  logic        dec_valid_in,
  input  logic [2:0]  dec_unit_sel_in,
  input  logic [3:0]  dec_uop_in,
  output logic        dec_ready_out,
  input  logic        int_done_in,
  input  logic        vec_done_in,
  input  logic        lsu_done_in,
  output logic [2:0]  exec_unit_sel_out,
  output logic [3:0]  exec_uop_out,
  output logic        issue_valid_out,
  output logic        illegal_sel_out,
  output logic [15:0] stall_count_out
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef logic [1:0] credit_t;

  localparam credit_t INT_MAX = credit_t'(INT_CREDITS);
  localparam credit_t VEC_MAX = credit_t'(VEC_CREDITS);
  localparam credit_t LSU_MAX = credit_t'(LSU_CREDITS);

  // Issue and retire to the same unit in one cycle cancel out; a retire with
  // the credit already at its ceiling is dropped so the counter cannot wrap.
  function automatic credit_t credit_next(input credit_t cur, input logic take,
                                          input logic give, input credit_t max);
    credit_t res;
    res = cur;
    if (take && !give)
      res = cur - 2'd1;
    else if (give && !take && (cur != max))
      res = cur + 2'd1;
    return res;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] cur);
    return (cur == 16'hFFFF) ? cur : cur + 16'd1;
  endfunction

  logic [2:0]       sel_mem [QUEUE_DEPTH];
  logic [3:0]       uop_mem [QUEUE_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  credit_t          int_credit;
  credit_t          vec_credit;
  credit_t          lsu_credit;

  logic       empty;
  logic       full;
  logic       accept;
  logic       sel_legal;
  logic       wr_en;
  logic [2:0] head_sel;
  logic [3:0] head_uop;
  logic       head_has_credit;
  logic       pop;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(QUEUE_DEPTH));
  assign sel_legal = (dec_unit_sel_in == 3'b001) || (dec_unit_sel_in == 3'b010) ||
                     (dec_unit_sel_in == 3'b100);

  assign dec_ready_out = !full && !flush_in;
  assign accept        = dec_valid_in && dec_ready_out;
  // Illegal selects still complete the handshake but are never stored.
  assign wr_en         = accept && sel_legal;

  assign head_sel = sel_mem[rd_ptr];
  assign head_uop = uop_mem[rd_ptr];

  // Stored selects are always one-hot; when the queue is empty the head slot
  // may hold stale contents, which is harmless because empty gates the issue.
  always_comb begin
    head_has_credit = 1'b0;
    if (head_sel[0])
      head_has_credit = (int_credit != 2'd0);
    else if (head_sel[1])
      head_has_credit = (vec_credit != 2'd0);
    else if (head_sel[2])
      head_has_credit = (lsu_credit != 2'd0);
  end

  assign issue_valid_out   = !empty && !flush_in && head_has_credit;
  assign pop               = issue_valid_out;
  assign exec_unit_sel_out = issue_valid_out ? head_sel : 3'b000;
  assign exec_uop_out      = issue_valid_out ? head_uop : 4'b0000;

  // Queue storage: data only, no reset needed.
  always_ff @(posedge clock_in) begin
    if (wr_en) begin
      sel_mem[wr_ptr] <= dec_unit_sel_in;
      uop_mem[wr_ptr] <= dec_uop_in;
    end
  end

  // Queue control: pointers wrap naturally since QUEUE_DEPTH is a power of two.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)
        rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Credits keep tracking retirements through a flush: in-flight ops are not
  // affected by discarding the queue.
  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      int_credit <= INT_MAX;
      vec_credit <= VEC_MAX;
      lsu_credit <= LSU_MAX;
    end else begin
      int_credit <= credit_next(int_credit, pop && head_sel[0], int_done_in, INT_MAX);
      vec_credit <= credit_next(vec_credit, pop && head_sel[1], vec_done_in, VEC_MAX);
      lsu_credit <= credit_next(lsu_credit, pop && head_sel[2], lsu_done_in, LSU_MAX);
    end
  end

  always_ff @(posedge clock_in or negedge reset_in) begin
    if (!reset_in) begin
      illegal_sel_out <= 1'b0;
      stall_count_out <= 16'd0;
    end else begin
      illegal_sel_out <= accept && !sel_legal;
      if (!empty && !issue_valid_out && !flush_in)
        stall_count_out <= sat_inc16(stall_count_out);
    end
  end

endmodule

// File: tb/tb_issue_scheduler.sv
module tb_issue_scheduler;

  logic        clk = 1'b0;
  logic        reset_in;
  logic        flush_in;
  logic        dec_valid_in;
  logic [2:0]  dec_unit_sel_in;
  logic [3:0]  dec_uop_in;
  logic        dec_ready_out;
  logic        int_done_in;
  logic        vec_done_in;
  logic        lsu_done_in;
  logic [2:0]  exec_unit_sel_out;
  logic [3:0]  exec_uop_out;
  logic        issue_valid_out;
  logic        illegal_sel_out;
  logic [15:0] stall_count_out;

  int vectors     = 0;
  int miscompares = 0;

  logic [6:0] sb [$];

  issue_scheduler #(
    .QUEUE_DEPTH(4),
    .INT_CREDITS(1),
    .VEC_CREDITS(2),
    .LSU_CREDITS(2)
  ) dut (
    .clock_in          (clk),
    .reset_in          (reset_in),
    .flush_in          (flush_in),
    .dec_valid_in      (dec_valid_in),
    .dec_unit_sel_in   (dec_unit_sel_in),
    .dec_uop_in        (dec_uop_in),
    .dec_ready_out     (dec_ready_out),
    .int_done_in       (int_done_in),
    .vec_done_in       (vec_done_in),
    .lsu_done_in       (lsu_done_in),
    .exec_unit_sel_out (exec_unit_sel_out),
    .exec_uop_out      (exec_uop_out),
    .issue_valid_out   (issue_valid_out),
    .illegal_sel_out   (illegal_sel_out),
    .stall_count_out   (stall_count_out)
  );

  always #5 clk = ~clk;

  localparam logic [2:0] INT = 3'b001;
  localparam logic [2:0] VEC = 3'b010;
  localparam logic [2:0] LSU = 3'b100;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_onehot(input logic [2:0] s);
    return (s == INT) || (s == VEC) || (s == LSU);
  endfunction

  // Compare the issue port against the scoreboard head when an issue is seen.
  task automatic observe(input logic exp_issue);
    logic [6:0] e;
    chk("issue_valid", 16'(issue_valid_out), 16'(exp_issue));
    if (issue_valid_out === 1'b1) begin
      chk("sb_nonempty", 16'(sb.size() != 0), 16'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("exec_sel", 16'(exec_unit_sel_out), 16'(e[6:4]));
        chk("exec_uop", 16'(exec_uop_out), 16'(e[3:0]));
      end
    end else begin
      chk("idle_sel", 16'(exec_unit_sel_out), 16'd0);
      chk("idle_uop", 16'(exec_uop_out), 16'd0);
    end
  endtask

  // One cycle: drive on the falling edge, check 1 time unit later.
  task automatic step(input logic v, input logic [2:0] s, input logic [3:0] u,
                      input logic id, input logic vd, input logic ld, input logic fl,
                      input logic exp_rdy, input logic exp_issue);
    @(negedge clk);
    dec_valid_in    = v;
    dec_unit_sel_in = s;
    dec_uop_in      = u;
    int_done_in     = id;
    vec_done_in     = vd;
    lsu_done_in     = ld;
    flush_in        = fl;
    #1;
    chk("dec_ready", 16'(dec_ready_out), 16'(exp_rdy));
    if (v && exp_rdy && is_onehot(s))
      sb.push_back({s, u});
    observe(exp_issue);
    if (fl)
      sb.delete();
  endtask

  task automatic push(input logic [2:0] s, input logic [3:0] u, input logic exp_issue);
    step(1'b1, s, u, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, exp_issue);
  endtask

  task automatic idle(input logic exp_issue);
    step(1'b0, 3'b000, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, exp_issue);
  endtask

  initial begin
    reset_in        = 1'b0;
    flush_in        = 1'b0;
    dec_valid_in    = 1'b0;
    dec_unit_sel_in = 3'b000;
    dec_uop_in      = 4'h0;
    int_done_in     = 1'b0;
    vec_done_in     = 1'b0;
    lsu_done_in     = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", 16'(dec_ready_out), 16'd1);
    observe(1'b0);
    chk("rst_stall", stall_count_out, 16'd0);
    chk("rst_illegal", 16'(illegal_sel_out), 16'd0);
    @(negedge clk);
    reset_in = 1'b1;

    // Back-to-back issue to different units, one cycle after enqueue.
    push(INT, 4'h3, 1'b0);
    push(VEC, 4'h5, 1'b1);
    idle(1'b1);
    idle(1'b0);
    step(1'b0, 3'b000, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Single INT credit: second INT waits for int_done.
    push(INT, 4'h1, 1'b0);
    push(INT, 4'h2, 1'b1);
    idle(1'b0);
    chk("stall_0", stall_count_out, 16'd0);
    idle(1'b0);
    chk("stall_1", stall_count_out, 16'd1);
    step(1'b0, 3'b000, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("stall_2", stall_count_out, 16'd2);
    idle(1'b1);
    chk("stall_3", stall_count_out, 16'd3);

    // Blocked INT head holds back younger LSU/VEC entries; fill the queue.
    push(INT, 4'h7, 1'b0);
    push(LSU, 4'h9, 1'b0);
    chk("stall_3b", stall_count_out, 16'd3);
    push(VEC, 4'hA, 1'b0);
    push(LSU, 4'hB, 1'b0);
    step(1'b1, LSU, 4'hC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("stall_6", stall_count_out, 16'd6);
    step(1'b0, 3'b000, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Full queue refuses even while the head issues.
    step(1'b1, LSU, 4'hC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    chk("stall_8", stall_count_out, 16'd8);
    idle(1'b1);
    idle(1'b1);
    step(1'b0, 3'b000, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);

    // Non-one-hot select: accepted, dropped, one-cycle illegal pulse.
    push(3'b011, 4'h5, 1'b0);
    chk("illegal_pre", 16'(illegal_sel_out), 16'd0);
    idle(1'b0);
    chk("illegal_pulse", 16'(illegal_sel_out), 16'd1);
    idle(1'b0);
    chk("illegal_clear", 16'(illegal_sel_out), 16'd0);

    // Flush with three queued entries; same-cycle vec_done still counts.
    push(VEC, 4'h6, 1'b0);
    push(INT, 4'h1, 1'b1);
    push(INT, 4'h2, 1'b1);
    push(VEC, 4'h3, 1'b0);
    push(LSU, 4'h4, 1'b0);
    step(1'b1, VEC, 4'h8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    chk("stall_flush", stall_count_out, 16'd10);
    // VEC back to two credits, INT still exhausted.
    push(VEC, 4'h1, 1'b0);
    push(VEC, 4'h2, 1'b1);
    push(VEC, 4'h3, 1'b1);
    idle(1'b0);
    step(1'b0, 3'b000, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    push(INT, 4'h5, 1'b1);
    idle(1'b0);

    // Asynchronous reset mid-traffic.
    @(negedge clk);
    reset_in = 1'b0;
    #1;
    chk("mid_rst_ready", 16'(dec_ready_out), 16'd1);
    chk("mid_rst_issue", 16'(issue_valid_out), 16'd0);
    chk("mid_rst_sel", 16'(exec_unit_sel_out), 16'd0);
    chk("mid_rst_uop", 16'(exec_uop_out), 16'd0);
    chk("mid_rst_stall", stall_count_out, 16'd0);
    sb.delete();
    @(negedge clk);
    reset_in = 1'b1;

    // INT credit restored to one; an extra done at max must not add a second.
    step(1'b0, 3'b000, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    push(INT, 4'h6, 1'b0);
    push(INT, 4'h7, 1'b1);
    idle(1'b0);
    idle(1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
